uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of byte requesters sharing one uart_tx; legal range 2..8.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 2000: maximum cycles to wait for tx_done before abandoning a byte.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ bits: requester i has a byte pending.
REQ-006 The block SHALL have port req_data, input, NUM_REQ*8 bits: byte of requester i on bits [8i+7:8i].
REQ-007 The block SHALL have port req_last, input, NUM_REQ bits: requester i's byte ends its message.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: a byte is accepted when req_valid[i] and req_ready[i] are both high.
REQ-009 The block SHALL have port tx_axiiv, output, 1 bit: start pulse to uart_tx.
REQ-010 The block SHALL have port tx_axiid, output, 8 bits: byte to uart_tx.
REQ-011 The block SHALL have port tx_done, input, 1 bit: one-cycle pulse from uart_tx when the byte has finished shifting out.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-013 The block SHALL have port grant_id, output, $clog2(NUM_REQ) bits: current or most recent granted requester.
REQ-014 The block SHALL have port timeout_err, output, 1 bit: one-cycle pulse when a tx_done timeout occurs.

Function
REQ-015 The state machine SHALL have three states: IDLE, ISSUE, WAIT_DONE.
REQ-016 In IDLE with no message lock, the block SHALL pick the grant round-robin, starting the search at the index after last_grant and wrapping from NUM_REQ-1 to 0.
REQ-017 In IDLE with a message lock held, the block SHALL consider only the locked requester; all other requests wait.
REQ-018 In IDLE, req_ready SHALL be combinationally one-hot at the chosen index when that index's req_valid is high, and zero otherwise; req_ready SHALL be zero in every other state.
REQ-019 On an accept in cycle N, the block SHALL latch data and last, update last_grant and grant_id, and move to ISSUE.
REQ-020 In ISSUE (cycle N+1), tx_axiiv SHALL be high for exactly one cycle with tx_axiid holding the latched byte; the state then moves to WAIT_DONE.
REQ-021 tx_axiid SHALL hold the latched byte until the next accept.
REQ-022 In WAIT_DONE, on tx_done, the block SHALL return to IDLE, setting lock = !latched_last and locking on grant_id.
REQ-023 A tx_done seen in IDLE or ISSUE SHALL be ignored.
REQ-024 The WAIT_DONE cycle counter SHALL start at 0 on entry; when it reaches TIMEOUT_CYCLES-1 without tx_done, the block SHALL pulse timeout_err, clear the lock, and return to IDLE.
REQ-025 If tx_done and the timeout coincide, tx_done SHALL win and no timeout_err is raised.
REQ-026 If a locked requester drops req_valid, the block SHALL stay locked and keep waiting; only the lock owner sending last=1, a timeout, or reset releases the lock.
REQ-027 Back-to-back throughput SHALL be one byte per (2 + uart_tx byte time) cycles, with no extra idle cycle beyond the IDLE accept cycle.

Reset
REQ-028 While rst is low at a clock edge, the block SHALL clear state to IDLE, last_grant to NUM_REQ-1 (so requester 0 wins first), grant_id to 0, lock to 0, the counter to 0, tx_axiid to 0, and tx_axiiv, timeout_err and busy to 0.
REQ-029 A reset mid-byte SHALL abandon the byte and SHALL NOT produce a further tx_axiiv or req_ready.

Structure
REQ-030 Package uart_pkg SHALL hold the state enum arb_state_t (IDLE, ISSUE, WAIT_DONE) and the constant BYTE_W = 8.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs: request vector, last_grant; outputs: grant index, found flag), instantiated once.

Verification
REQ-032 The bench SHALL cover: reset, then req_valid=0001, data 0xAA, last=1 -> req_ready[0] in the same cycle, tx_axiiv one cycle later with 0xAA, busy until tx_done.
REQ-033 The bench SHALL cover: all four requesters valid with last=1 -> grants in order 0,1,2,3,0, each tx_axiiv one cycle after its accept.
REQ-034 The bench SHALL cover: requester 2 sends 0x11 (last=0), 0x22 (last=0), 0x33 (last=1) while requester 1 stays valid -> all three bytes go out before any byte from requester 1.
REQ-035 The bench SHALL cover: tx_done withheld with TIMEOUT_CYCLES=16 -> timeout_err pulses 16 cycles after WAIT_DONE entry, lock clears, and the next requester is granted.
REQ-036 The bench SHALL cover: reset asserted in WAIT_DONE -> all outputs at reset values next cycle, and a late tx_done causes no activity.
REQ-037 The bench SHALL cover: tx_done pulsed in IDLE with no requests -> no state change and no req_ready.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_tx arbiter.
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_grant, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      grant,
  output logic               found
);

  logic [IW-1:0] idx;

  // Scan NUM_REQ slots starting one past last_grant; last_grant itself is checked last.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = IW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates byte requesters onto one uart_tx, holding the grant for multi-byte messages.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 2000,
  localparam int IW            = $clog2(NUM_REQ),
  localparam int CW            = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_axiiv,
  output logic [BYTE_W-1:0]         tx_axiid,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [IW-1:0]             grant_id,
  output logic                      timeout_err
);

  arb_state_t          state_q, state_d;
  logic [IW-1:0]       last_grant_q, last_grant_d;
  logic [IW-1:0]       grant_id_q, grant_id_d;
  logic                lock_q, lock_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                last_q, last_d;
  logic                timeout_q, timeout_d;

  logic [IW-1:0]       rr_grant;
  logic                rr_found;
  logic [IW-1:0]       cand;
  logic                cand_ok;
  logic                accept;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (rr_grant),
    .found      (rr_found)
  );

  // Candidate is the lock owner while a message is in flight, otherwise the round-robin pick.
  // req_ready is gated by reset so a held request cannot see a handshake during reset.
  always_comb begin
    cand      = lock_q ? grant_id_q : rr_grant;
    cand_ok   = lock_q ? req_valid[grant_id_q] : rr_found;
    req_ready = '0;
    if (rst && (state_q == IDLE) && cand_ok) req_ready[cand] = 1'b1;
    accept    = |req_ready;
  end

  // Next-state logic: accept in IDLE, one-cycle start pulse in ISSUE, then wait for done or timeout.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    lock_d       = lock_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    last_d       = last_q;
    timeout_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d       = req_data[int'(cand)*BYTE_W +: BYTE_W];
          last_d       = req_last[cand];
          last_grant_d = cand;
          grant_id_d   = cand;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // tx_done takes priority over a timeout landing in the same cycle.
        if (tx_done) begin
          state_d = IDLE;
          lock_d  = !last_q;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          lock_d    = 1'b0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; last_grant starts at the top so 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      lock_q       <= 1'b0;
      cnt_q        <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      lock_q       <= lock_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      last_q       <= last_d;
      timeout_q    <= timeout_d;
    end
  end

  assign tx_axiiv    = (state_q == ISSUE);
  assign tx_axiid    = data_q;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_q;

endmodule
